stream_packer: RTL and testbench

Width-up converter that sits directly downstream of the accelerator's word FIFOs. It consumes narrow words over a valid/ready stream and packs RATIO consecutive words into one wide beat for the wide datapath or memory write port. The block supports packet termination via a last flag, with partial beats zero-padded and lane-masked. It sustains one input word per cycle under no backpressure, and its two beat stages give the output a registered, stall-stable interface.

---
 rtl/stream_packer.sv | 120 ++++++++++++
 tb/tb_stream_packer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packer.sv
`timescale 1ns/1ps
// Packs RATIO consecutive IN_WIDTH words into one OUT_WIDTH beat; a last word closes a partial, zero-padded beat.
// Latency: a completing word accepted at edge k shows outValidOut=1 in cycle k+1 when the output slot is free.
// Backpressure: one beat in the output register plus one pending in the accumulator; inReadyOut drops while pending.
//
// Ports:
//   clkIn / rstNIn            clock, synchronous active-low reset
//   inDataIn/inLastIn         narrow word and end-of-packet flag
//   inValidIn/inReadyOut      input handshake (inReadyOut is a flop)
//   outDataOut/outKeepOut     packed beat, lane i at [i*IN_WIDTH +: IN_WIDTH], keep bit per lane
//   outLastOut                beat ends a packet
//   outValidOut/outReadyIn    output handshake (outValidOut is a flop)
module stream_packer #(
  parameter  int IN_WIDTH  = 32,
  parameter  int RATIO     = 4,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                 clkIn,
  input  logic                 rstNIn,
  input  logic [IN_WIDTH-1:0]  inDataIn,
  input  logic                 inLastIn,
  input  logic                 inValidIn,
  output logic                 inReadyOut,
  output logic [OUT_WIDTH-1:0] outDataOut,
  output logic [RATIO-1:0]     outKeepOut,
  output logic                 outLastOut,
  output logic                 outValidOut,
  input  logic                 outReadyIn
);

  localparam int LANE_W = $clog2(RATIO);

  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic [RATIO-1:0]     keep;
    logic                 last;
  } beatT;

  beatT              accR;       // accumulator; holds the completed beat while pendingR
  beatT              outR;       // output register
  beatT              newBeat;    // accumulator with the incoming word merged in
  logic [LANE_W-1:0] laneR;
  logic              pendingR;
  logic              inReadyR;
  logic              outValidR;

  logic accept;
  logic complete;
  logic slotFree;

  assign accept   = inValidIn & inReadyR;
  assign slotFree = ~outValidR | outReadyIn;
  assign complete = accept & (inLastIn | (laneR == LANE_W'(RATIO - 1)));

  // Lanes above the current one are still zero because the accumulator is
  // cleared every time a beat leaves it, which gives the zero padding for free.
  always_comb begin
    newBeat = accR;
    for (int i = 0; i < RATIO; i++) begin
      if (laneR == LANE_W'(i)) begin
        newBeat.data[i*IN_WIDTH +: IN_WIDTH] = inDataIn;
        newBeat.keep[i]                      = 1'b1;
      end
    end
    newBeat.last = inLastIn;
  end

  always_ff @(posedge clkIn) begin
    if (!rstNIn) begin
      accR      <= '0;
      outR      <= '0;
      laneR     <= '0;
      pendingR  <= 1'b0;
      inReadyR  <= 1'b0;
      outValidR <= 1'b0;
    end else begin
      // Drain by default; a load below overrides it, so drain and load on the
      // same edge keep outValidR high with no bubble.
      if (outValidR && outReadyIn) begin
        outValidR <= 1'b0;
      end

      if (pendingR) begin
        // No words are accepted while pending, since inReadyR is low.
        if (slotFree) begin
          outR      <= accR;
          outValidR <= 1'b1;
          accR      <= '0;
          pendingR  <= 1'b0;
          inReadyR  <= 1'b1;
        end
      end else begin
        inReadyR <= 1'b1;
        if (complete) begin
          laneR <= '0;
          if (slotFree) begin
            outR      <= newBeat;
            outValidR <= 1'b1;
            accR      <= '0;
          end else begin
            // Park the finished beat in the accumulator and stop input.
            accR     <= newBeat;
            pendingR <= 1'b1;
            inReadyR <= 1'b0;
          end
        end else if (accept) begin
          accR  <= newBeat;
          laneR <= laneR + LANE_W'(1);
        end
      end
    end
  end

  assign inReadyOut  = inReadyR;
  assign outValidOut = outValidR;
  assign outDataOut  = outR.data;
  assign outKeepOut  = outR.keep;
  assign outLastOut  = outR.last;

endmodule

// File: tb/tb_stream_packer.sv
`timescale 1ns/1ps
module tb_stream_packer;

  localparam int IW = 32;
  localparam int R  = 4;
  localparam int OW = IW * R;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [R-1:0]  keep;
    logic          last;
  } beatT;

  logic          clkIn = 1'b0;
  logic          rstNIn;
  logic [IW-1:0] inDataIn;
  logic          inLastIn;
  logic          inValidIn;
  logic          inReadyOut;
  logic [OW-1:0] outDataOut;
  logic [R-1:0]  outKeepOut;
  logic          outLastOut;
  logic          outValidOut;
  logic          outReadyIn;

  int total = 0;
  int bad   = 0;

  // Reference model state: words of the packet being built, expected beats,
  // and every beat seen leaving the DUT.
  logic [IW-1:0] partial[$];
  beatT          expQ[$];
  beatT          gotBeats[$];
  int            beatsSeen = 0;

  logic          prevStall = 1'b0;
  beatT          prevBeat;

  stream_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (
    .clkIn      (clkIn),
    .rstNIn     (rstNIn),
    .inDataIn   (inDataIn),
    .inLastIn   (inLastIn),
    .inValidIn  (inValidIn),
    .inReadyOut (inReadyOut),
    .outDataOut (outDataOut),
    .outKeepOut (outKeepOut),
    .outLastOut (outLastOut),
    .outValidOut(outValidOut),
    .outReadyIn (outReadyIn)
  );

  always #5 clkIn = ~clkIn;

  task automatic checkVal(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Build the expected beat from the words collected so far.
  function automatic beatT mkBeat(input logic last);
    beatT b;
    b = '0;
    for (int i = 0; i < partial.size(); i++) begin
      b.data[i*IW +: IW] = partial[i];
      b.keep[i]          = 1'b1;
    end
    b.last = last;
    return b;
  endfunction

  // Monitor + scoreboard, sampled mid-cycle; inputs change just after posedge.
  always @(negedge clkIn) begin
    beatT e;
    if (!rstNIn) begin
      partial.delete();
      expQ.delete();
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkVal("stall_vld",  OW'(outValidOut), OW'(1));
        checkVal("stall_data", outDataOut, prevBeat.data);
        checkVal("stall_keep", OW'(outKeepOut), OW'(prevBeat.keep));
        checkVal("stall_last", OW'(outLastOut), OW'(prevBeat.last));
      end
      if (outValidOut && outReadyIn) begin
        checkVal("beat_expected", OW'(expQ.size() != 0), OW'(1));
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkVal("sb_data", outDataOut, e.data);
          checkVal("sb_keep", OW'(outKeepOut), OW'(e.keep));
          checkVal("sb_last", OW'(outLastOut), OW'(e.last));
        end
        gotBeats.push_back({outDataOut, outKeepOut, outLastOut});
        beatsSeen++;
      end
      if (inValidIn && inReadyOut) begin
        partial.push_back(inDataIn);
        if (partial.size() == R || inLastIn) begin
          expQ.push_back(mkBeat(inLastIn));
          partial.delete();
        end
      end
      prevStall = outValidOut && !outReadyIn;
      prevBeat  = {outDataOut, outKeepOut, outLastOut};
    end
  end

  // Offer one word and hold it until accepted; called just after a posedge.
  task automatic pushWord(input logic [IW-1:0] d, input logic l, output int stalls);
    int waited = 0;
    bit done   = 0;
    inValidIn = 1'b1;
    inDataIn  = d;
    inLastIn  = l;
    while (!done) begin
      @(negedge clkIn);
      if (inReadyOut) done = 1;
      else waited++;
      @(posedge clkIn);
      #1;
      if (!done && waited > 2000) begin
        checkVal("push_timeout", OW'(waited), OW'(0));
        done = 1;
      end
    end
    inValidIn = 1'b0;
    inLastIn  = 1'b0;
    stalls    = waited;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clkIn);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, sum, base, s9;
    bit randDone;

    rstNIn = 1'b0; inValidIn = 1'b0; inDataIn = '0; inLastIn = 1'b0; outReadyIn = 1'b0;
    repeat (3) @(posedge clkIn);
    @(negedge clkIn);
    checkVal("rst_valid", OW'(outValidOut), OW'(0));
    checkVal("rst_data",  outDataOut, OW'(0));
    checkVal("rst_keep",  OW'(outKeepOut), OW'(0));
    checkVal("rst_last",  OW'(outLastOut), OW'(0));
    checkVal("rst_ready", OW'(inReadyOut), OW'(0));
    @(posedge clkIn); #1;
    rstNIn = 1'b1;
    @(negedge clkIn);
    checkVal("ready_first_cycle", OW'(inReadyOut), OW'(0));
    @(posedge clkIn); #1;
    @(negedge clkIn);
    checkVal("ready_after_rst", OW'(inReadyOut), OW'(1));
    @(posedge clkIn); #1;

    // Full-rate packing.
    outReadyIn = 1'b1;
    base = gotBeats.size();
    sum = 0;
    for (int i = 1; i <= 8; i++) begin
      pushWord(IW'(i), i == 8, s);
      sum += s;
    end
    @(negedge clkIn);
    checkVal("lat_valid", OW'(outValidOut), OW'(1));
    checkVal("lat_last",  OW'(outLastOut), OW'(1));
    idle(3);
    checkVal("full_stalls", OW'(sum), OW'(0));
    checkVal("full_count", OW'(gotBeats.size() - base), OW'(2));
    if (gotBeats.size() - base == 2) begin
      checkVal("full_b1_data", gotBeats[base].data, 128'h00000004_00000003_00000002_00000001);
      checkVal("full_b1_keep", OW'(gotBeats[base].keep), OW'(4'b1111));
      checkVal("full_b1_last", OW'(gotBeats[base].last), OW'(0));
      checkVal("full_b2_data", gotBeats[base+1].data, 128'h00000008_00000007_00000006_00000005);
      checkVal("full_b2_keep", OW'(gotBeats[base+1].keep), OW'(4'b1111));
      checkVal("full_b2_last", OW'(gotBeats[base+1].last), OW'(1));
    end

    // Partial packet, then a word that must land in lane 0.
    base = gotBeats.size();
    pushWord(32'hA, 1'b0, s);
    pushWord(32'hB, 1'b0, s);
    pushWord(32'hC, 1'b1, s);
    pushWord(32'hD, 1'b1, s);
    idle(3);
    checkVal("part_count", OW'(gotBeats.size() - base), OW'(2));
    if (gotBeats.size() - base == 2) begin
      checkVal("part_data", gotBeats[base].data, 128'h00000000_0000000C_0000000B_0000000A);
      checkVal("part_keep", OW'(gotBeats[base].keep), OW'(4'b0111));
      checkVal("part_last", OW'(gotBeats[base].last), OW'(1));
      checkVal("lane0_data", gotBeats[base+1].data, OW'(32'hD));
      checkVal("lane0_keep", OW'(gotBeats[base+1].keep), OW'(4'b0001));
    end

    // Single-word packet.
    base = gotBeats.size();
    pushWord(32'h55, 1'b1, s);
    idle(3);
    checkVal("single_count", OW'(gotBeats.size() - base), OW'(1));
    if (gotBeats.size() - base == 1) begin
      checkVal("single_data", gotBeats[base].data, OW'(32'h55));
      checkVal("single_keep", OW'(gotBeats[base].keep), OW'(4'b0001));
      checkVal("single_last", OW'(gotBeats[base].last), OW'(1));
    end

    // Backpressure: two beats buffered, ninth word stalls.
    outReadyIn = 1'b0;
    base = gotBeats.size();
    sum = 0;
    for (int i = 1; i <= 8; i++) begin
      pushWord(32'h100 + IW'(i), 1'b0, s);
      sum += s;
    end
    checkVal("bp_fill_stalls", OW'(sum), OW'(0));
    @(negedge clkIn);
    checkVal("bp_ready_low", OW'(inReadyOut), OW'(0));
    checkVal("bp_out_valid", OW'(outValidOut), OW'(1));
    checkVal("bp_out_data", outDataOut, 128'h00000104_00000103_00000102_00000101);
    @(posedge clkIn); #1;
    fork
      pushWord(32'h109, 1'b0, s9);
      begin
        idle(4);
        outReadyIn = 1'b1;
      end
    join
    checkVal("bp_word9_stalls", OW'(s9), OW'(5));
    checkVal("bp_count", OW'(gotBeats.size() - base), OW'(2));
    if (gotBeats.size() - base == 2) begin
      checkVal("bp_b1_data", gotBeats[base].data, 128'h00000104_00000103_00000102_00000101);
      checkVal("bp_b2_data", gotBeats[base+1].data, 128'h00000108_00000107_00000106_00000105);
    end

    // Reset mid-packet (word 0x109 and two more are in the accumulator).
    pushWord(32'h201, 1'b0, s);
    pushWord(32'h202, 1'b0, s);
    base = gotBeats.size();
    rstNIn = 1'b0;
    @(posedge clkIn); #1;
    rstNIn = 1'b1;
    @(negedge clkIn);
    checkVal("mid_rst_valid", OW'(outValidOut), OW'(0));
    checkVal("mid_rst_data",  outDataOut, OW'(0));
    checkVal("mid_rst_keep",  OW'(outKeepOut), OW'(0));
    checkVal("mid_rst_ready", OW'(inReadyOut), OW'(0));
    @(posedge clkIn); #1;
    @(negedge clkIn);
    checkVal("mid_rst_ready_back", OW'(inReadyOut), OW'(1));
    @(posedge clkIn); #1;
    idle(2);
    checkVal("mid_rst_no_beat", OW'(gotBeats.size() - base), OW'(0));
    for (int i = 1; i <= 4; i++) pushWord(32'h300 + IW'(i), 1'b0, s);
    idle(3);
    checkVal("post_rst_count", OW'(gotBeats.size() - base), OW'(1));
    if (gotBeats.size() - base == 1) begin
      checkVal("post_rst_data", gotBeats[base].data, 128'h00000304_00000303_00000302_00000301);
      checkVal("post_rst_keep", OW'(gotBeats[base].keep), OW'(4'b1111));
    end

    // Random valid/ready and random last, scoreboard does the checking.
    base = beatsSeen;
    randDone = 0;
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          while ($urandom_range(1, 0) == 0) idle(1);
          pushWord($urandom, $urandom_range(7, 0) == 0, s);
        end
        randDone = 1;
      end
      begin
        while (!randDone) begin
          @(posedge clkIn); #1;
          outReadyIn = $urandom_range(1, 0) == 1;
        end
      end
    join
    outReadyIn = 1'b1;
    pushWord(32'hFFFF, 1'b1, s);
    idle(5);
    checkVal("rand_exp_empty", OW'(expQ.size()), OW'(0));
    checkVal("rand_partial_empty", OW'(partial.size()), OW'(0));
    checkVal("rand_beats_seen", OW'(beatsSeen - base > 2500), OW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
